if_prefetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue and a variable-latency

---
 rtl/if_pkg.sv | 16 +
 rtl/if_prefetch_stage_if.sv | 28 ++
 rtl/if_fetch_fifo.sv | 64 ++++++
 rtl/if_prefetch_stage.sv | 123 ++++++++++++
 tb/tb_if_prefetch_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared defaults and types for the instruction-fetch prefetch stage.
package if_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam int unsigned DEF_PC_STEP = 4;

    // pc is the fetch address + PC_STEP, i.e. what ID sees as PC.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_prefetch_stage_if
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr} entries with flush.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    // NOTE: storage has no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests feeding a prefetch queue
// and a registered PC/Instruction/valid output toward ID.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        INSTR_W  = DEF_INSTR_W,
    parameter int unsigned        DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = DEF_RESET_PC,
    parameter int unsigned        PC_STEP  = DEF_PC_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                Branch_taken,
    input  logic [ADDR_W-1:0]   BranchAddr,
    if_prefetch_stage_if.master imem,
    output logic                valid,
    output logic [ADDR_W-1:0]   PC,
    output logic [INSTR_W-1:0]  Instruction
);

    localparam int unsigned       CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              discard;

    logic              issue;
    logic              resp_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    entry_t            push_entry;
    entry_t            head;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        occupancy  = '0;
        issue      = 1'b0;
        fifo_pop   = 1'b0;
        resp_push  = 1'b0;
        push_entry = '{pc: req_pc + STEP, instr: imem.imem_rdata};

        // The response owed to an outstanding request is charged a slot up front.
        occupancy = {1'b0, fifo_count} + (CNT_W+1)'(outstanding);
        issue     = !rst && !Branch_taken
                 && (!outstanding || imem.imem_rvalid)
                 && (occupancy < (CNT_W+1)'(DEPTH));
        fifo_pop  = !freeze && !Branch_taken && !fifo_empty;
        resp_push = imem.imem_rvalid && !discard && !Branch_taken
                 && (!fifo_full || fifo_pop);
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = issue ? fetch_pc : '0;

    if_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (Branch_taken),
        .push      (resp_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (Branch_taken) begin
            // A request still in flight will return stale data; mark it for dropping.
            fetch_pc    <= BranchAddr;
            outstanding <= outstanding && !imem.imem_rvalid;
            discard     <= outstanding && !imem.imem_rvalid;
        end else begin
            if (imem.imem_rvalid) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (issue) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            PC          <= '0;
            Instruction <= '0;
        end else if (Branch_taken) begin
            valid <= 1'b0;
        end else if (!freeze) begin
            valid <= !fifo_empty;
            if (!fifo_empty) begin
                PC          <= head.pc;
                Instruction <= head.instr;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomised bench for if_prefetch_stage against a queue-based reference model.
module tb_if_prefetch_stage;
    import if_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;
    localparam logic [31:0] RPC   = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] baddr = '0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    if_prefetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) imem ();

    if_prefetch_stage #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (bt),
        .BranchAddr   (baddr),
        .imem         (imem),
        .valid        (valid),
        .PC           (pc),
        .Instruction  (instr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory model: answers the request it actually saw after a random latency.
    bit          mem_busy = 0;
    int          mem_left = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] data_xor = '0;

    // Reference model: the prefetch queue as an SV queue plus a few flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    bit          m_out;
    bit          m_disc;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic [31:0] m_opc;
    logic [31:0] m_oinstr;

    task automatic model_reset();
        mq.delete();
        m_out    = 0;
        m_disc   = 0;
        m_valid  = 0;
        m_pc     = RPC;
        m_req_pc = '0;
        m_opc    = '0;
        m_oinstr = '0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_req"},   imem.imem_req,  0);
        check({pfx, "_addr"},  imem.imem_addr, 0);
        check({pfx, "_valid"}, valid,          0);
        check({pfx, "_pc"},    pc,             0);
        check({pfx, "_instr"}, instr,          0);
    endtask

    task automatic mem_advance();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
        if (rst) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_addr ^ data_xor;
                mem_busy         = 0;
            end
        end
    endtask

    // Compare at mid-cycle, then advance the model across the coming rising edge.
    task automatic mid_cycle();
        bit          exp_req;
        bit          do_push;
        ent_t        pushed;
        ent_t        e;
        if (rst) begin
            check_zero("rst");
            model_reset();
            return;
        end
        exp_req = !bt && (!m_out || imem.imem_rvalid) && ((mq.size() + int'(m_out)) < DEPTH);
        check("req",   imem.imem_req,  exp_req);
        check("addr",  imem.imem_addr, exp_req ? m_pc : 32'd0);
        check("valid", valid,          m_valid);
        check("pc",    pc,             m_opc);
        check("instr", instr,          m_oinstr);

        if (imem.imem_req) begin
            mem_busy = 1;
            mem_left = $urandom_range(lat_max, lat_min);
            mem_addr = imem.imem_addr;
        end

        if (bt) begin
            if (imem.imem_rvalid) begin
                m_out  = 0;
                m_disc = 0;
            end else if (m_out) begin
                m_disc = 1;
            end
            mq.delete();
            m_valid = 0;
            m_pc    = baddr;
        end else begin
            do_push = 0;
            if (imem.imem_rvalid) begin
                if (m_disc) m_disc = 0;
                else begin
                    do_push = 1;
                    pushed  = '{pc: m_req_pc + STEP, instr: imem.imem_rdata};
                end
                m_out = 0;
            end
            if (!freeze) begin
                if (mq.size() > 0) begin
                    e        = mq.pop_front();
                    m_valid  = 1;
                    m_opc    = e.pc;
                    m_oinstr = e.instr;
                end else begin
                    m_valid = 0;
                end
            end
            if (do_push) mq.push_back(pushed);
            if (exp_req) begin
                m_out    = 1;
                m_req_pc = m_pc;
                m_pc     = m_pc + STEP;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mid_cycle();
        @(posedge clk);
        #1;
        mem_advance();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #1 check_zero("init");
        ticks(2);
        rst = 1'b0;

        // 1. Streaming with a 1-cycle memory returning addr as data
        ticks(20);

        // 2. Freeze mid-stream, then drain
        freeze = 1'b1;
        ticks(10);
        check("frz_req_idle", imem.imem_req, 0);
        freeze = 1'b0;
        ticks(10);

        // 3. Branch with a 3-cycle response in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(mem_busy && !imem.imem_rvalid); i++) tick();
        check("wait_inflight", mem_busy && !imem.imem_rvalid, 1);
        bt = 1'b1; baddr = 32'h100;
        tick();
        bt = 1'b0;
        #1;
        for (int i = 0; i < 10 && !imem.imem_req; i++) begin
            tick();
            #1;
        end
        check("br_target_addr", imem.imem_addr, 32'h100);
        lat_min = 1; lat_max = 1;
        ticks(10);

        // 4. Branch coinciding with a response, while frozen
        lat_min = 2; lat_max = 2;
        freeze = 1'b1;
        ticks(3);
        for (int i = 0; i < 10 && !imem.imem_rvalid; i++) tick();
        check("wait_rvalid", imem.imem_rvalid, 1);
        bt = 1'b1; baddr = 32'h200;
        tick();
        bt = 1'b0;
        check("bt_freeze_valid", valid, 0);
        ticks(3);
        freeze = 1'b0;
        ticks(6);

        // 5. Address wrap at the top of the space
        lat_min = 1; lat_max = 1;
        bt = 1'b1; baddr = 32'hFFFF_FFF8;
        tick();
        bt = 1'b0;
        ticks(8);

        // Randomised traffic: latency, freeze, redirects, data
        lat_min = 1; lat_max = 3;
        data_xor = $urandom;
        for (int i = 0; i < 400; i++) begin
            freeze = ($urandom_range(9, 0) < 3);
            bt     = ($urandom_range(19, 0) == 0);
            baddr  = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        bt = 1'b0; freeze = 1'b0;

        // 6. Asynchronous reset mid-burst with a request outstanding
        lat_min = 3; lat_max = 3;
        freeze = 1'b1;
        ticks(3);
        for (int i = 0; i < 20 && !mem_busy; i++) tick();
        check("wait_busy", mem_busy, 1);
        rst = 1'b1;
        #1;
        check_zero("arst");
        mem_busy = 0;
        imem.imem_rvalid = 1'b0;
        model_reset();
        ticks(2);
        rst = 1'b0;
        freeze = 1'b0;
        #1;
        check("post_rst_req",  imem.imem_req,  1);
        check("post_rst_addr", imem.imem_addr, RPC);
        lat_min = 1; lat_max = 1;
        ticks(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
